register_stack: RTL and testbench

//  Parametrised LIFO register stack for the SAP datapath: DEPTH words of WIDTH bits with

---
 rtl/sap1_pkg.sv | 13 +
 rtl/register_stack_ctrl.sv | 118 +++++++++++
 rtl/register_stack.sv | 93 +++++++++
 tb/tb_register_stack.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP datapath.
//   WORD_W     default datapath word width
//   OP_*       stack operation encodings, formed as {push, pop}
package sap1_pkg;

   localparam int WORD_W = 8;

   localparam logic [1:0] OP_NONE    = 2'b00;
   localparam logic [1:0] OP_POP     = 2'b01;
   localparam logic [1:0] OP_PUSH    = 2'b10;
   localparam logic [1:0] OP_REPLACE = 2'b11;

endpackage

// File: rtl/register_stack_ctrl.sv
// Stack controller: occupancy counter, op decode, full/empty and sticky
// error flags. Produces one-hot per-slot write-enable and clear strobes
// for the storage array in the top level.
//   mclk, rst      clock, async active-high reset
//   mclk_en        clock enable
//   push, pop      operation request
//   clear_err      clear sticky flags (set wins on coincidence)
//   count_o        valid entries
//   full_o/empty_o occupancy status
//   overflow_o     sticky push-while-full
//   underflow_o    sticky pop-while-empty
//   wr_en_o        slot write strobes (load push data)
//   clr_o          slot clear strobes (zero vacated slot)
module stack_ctrl
   import sap1_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             mclk,
   input  logic             rst,
   input  logic             mclk_en,
   input  logic             push,
   input  logic             pop,
   input  logic             clear_err,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             overflow_o,
   output logic             underflow_o,
   output logic [DEPTH-1:0] wr_en_o,
   output logic [DEPTH-1:0] clr_o
);

   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [CNT_W-1:0] slot;
   logic             do_wr;
   logic             do_clr;
   logic             full;
   logic             empty;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      slot    = '0;
      do_wr   = 1'b0;
      do_clr  = 1'b0;
      wr_en_o = '0;
      clr_o   = '0;
      if (mclk_en) begin
         // Clear first so a coincident error below re-sets the flag.
         if (clear_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
         end
         case ({push, pop})
            OP_PUSH: begin
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  do_wr   = 1'b1;
                  slot    = count_q;
                  count_d = count_q + CNT_W'(1);
               end
            end
            OP_POP: begin
               if (empty) begin
                  unf_d = 1'b1;
               end else begin
                  do_clr  = 1'b1;
                  slot    = count_q - CNT_W'(1);
                  count_d = count_q - CNT_W'(1);
               end
            end
            OP_REPLACE: begin
               // Replace on an empty stack degrades to a plain push.
               do_wr = 1'b1;
               if (empty) begin
                  slot    = '0;
                  count_d = CNT_W'(1);
               end else begin
                  slot = count_q - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
      for (int i = 0; i < DEPTH; i++) begin
         wr_en_o[i] = do_wr  && (slot == CNT_W'(i));
         clr_o[i]   = do_clr && (slot == CNT_W'(i));
      end
   end

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign count_o     = count_q;
   assign full_o      = full;
   assign empty_o     = empty;
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;

endmodule

// File: rtl/register_stack.sv
// LIFO register stack: DEPTH words of WIDTH bits with push, pop and
// replace-top. Top of stack is always visible; slots above the count are
// held at zero.
//   mclk, rst      clock, async active-high reset
//   mclk_en        clock enable
//   i_push, i_pop  operation request ({push,pop})
//   i_push_data    word to push / replace top with
//   i_clear_err    clear sticky error flags
//   o_top          top-of-stack word, 0 when empty
//   o_count        valid entries
//   o_empty/o_full occupancy status
//   o_overflow     sticky push-while-full
//   o_underflow    sticky pop-while-empty
module register_stack
   import sap1_pkg::*;
#(
   parameter  int WIDTH = WORD_W,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             mclk,
   input  logic             rst,
   input  logic             mclk_en,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_clear_err,
   output logic [WIDTH-1:0] o_top,
   output logic [CNT_W-1:0] o_count,
   output logic             o_empty,
   output logic             o_full,
   output logic             o_overflow,
   output logic             o_underflow
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] wr_en;
   logic [DEPTH-1:0] clr;

   stack_ctrl #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_ctrl (
      .mclk        (mclk),
      .rst         (rst),
      .mclk_en     (mclk_en),
      .push        (i_push),
      .pop         (i_pop),
      .clear_err   (i_clear_err),
      .count_o     (o_count),
      .full_o      (o_full),
      .empty_o     (o_empty),
      .overflow_o  (o_overflow),
      .underflow_o (o_underflow),
      .wr_en_o     (wr_en),
      .clr_o       (clr)
   );

   // Strobes are already qualified by mclk_en inside the controller.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (wr_en[i]) begin
            mem_d[i] = i_push_data;
         end else if (clr[i]) begin
            mem_d[i] = '0;
         end
      end
   end

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   always_comb begin
      o_top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (o_count == CNT_W'(i + 1)) begin
            o_top = mem_q[i];
         end
      end
   end

endmodule

// File: tb/tb_register_stack.sv
module tb_register_stack;

   logic       mclk = 1'b0;
   logic       rst;
   logic       mclk_en;
   logic       i_push;
   logic       i_pop;
   logic [7:0] i_push_data;
   logic       i_clear_err;
   logic [7:0] o_top;
   logic [2:0] o_count;
   logic       o_empty;
   logic       o_full;
   logic       o_overflow;
   logic       o_underflow;

   int checks   = 0;
   int failures = 0;

   register_stack #(.WIDTH(8), .DEPTH(4)) dut (
      .mclk        (mclk),
      .rst         (rst),
      .mclk_en     (mclk_en),
      .i_push      (i_push),
      .i_pop       (i_pop),
      .i_push_data (i_push_data),
      .i_clear_err (i_clear_err),
      .o_top       (o_top),
      .o_count     (o_count),
      .o_empty     (o_empty),
      .o_full      (o_full),
      .o_overflow  (o_overflow),
      .o_underflow (o_underflow)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Check the whole visible state in one go.
   task automatic chk_state(input string tag, input logic [7:0] top, input logic [2:0] cnt,
                            input logic full, input logic empty, input logic ovf, input logic unf);
      chk({tag, ".top"},   32'(o_top),       32'(top));
      chk({tag, ".count"}, 32'(o_count),     32'(cnt));
      chk({tag, ".full"},  32'(o_full),      32'(full));
      chk({tag, ".empty"}, 32'(o_empty),     32'(empty));
      chk({tag, ".ovf"},   32'(o_overflow),  32'(ovf));
      chk({tag, ".unf"},   32'(o_underflow), 32'(unf));
   endtask

   // One clock with the given request, sampled 1 time unit after the edge.
   task automatic step(input logic en, input logic psh, input logic pp,
                       input logic [7:0] d, input logic clr);
      mclk_en     = en;
      i_push      = psh;
      i_pop       = pp;
      i_push_data = d;
      i_clear_err = clr;
      @(posedge mclk);
      #1;
      mclk_en     = 1'b1;
      i_push      = 1'b0;
      i_pop       = 1'b0;
      i_push_data = 8'h00;
      i_clear_err = 1'b0;
   endtask

   initial begin
      rst = 1'b1; mclk_en = 1'b1; i_push = 1'b0; i_pop = 1'b0;
      i_push_data = 8'h00; i_clear_err = 1'b0;
      #23;
      chk_state("reset", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge mclk); rst = 1'b0;

      // 1: three pushes
      step(1, 1, 0, 8'h11, 0);
      chk("t1.top1", 32'(o_top), 32'h11);
      step(1, 1, 0, 8'h22, 0);
      step(1, 1, 0, 8'h33, 0);
      chk_state("t1", 8'h33, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

      // 2: fill, overflow, clear, replace while full
      step(1, 1, 0, 8'h44, 0);
      chk_state("t2.full", 8'h44, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1, 1, 0, 8'hAA, 0);
      chk_state("t2.ovf", 8'h44, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1, 0, 0, 8'h00, 1);
      chk_state("t2.clr", 8'h44, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1, 1, 1, 8'h55, 0);
      chk_state("t2.repl", 8'h55, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);

      // 3: drain, underflow, replace on empty, set-wins-over-clear
      step(1, 0, 1, 8'h00, 0);
      chk("t3.pop1", 32'(o_top), 32'h33);
      step(1, 0, 1, 8'h00, 0);
      chk("t3.pop2", 32'(o_top), 32'h22);
      step(1, 0, 1, 8'h00, 0);
      step(1, 0, 1, 8'h00, 0);
      chk_state("t3.empty", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1, 0, 1, 8'h00, 0);
      chk_state("t3.unf", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1, 1, 1, 8'h5C, 0);
      chk_state("t3.repl", 8'h5C, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1, 0, 1, 8'h00, 0);
      step(1, 0, 1, 8'h00, 1);
      chk("t3.setwins", 32'(o_underflow), 32'h1);
      step(1, 0, 0, 8'h00, 1);
      chk("t3.unfclr", 32'(o_underflow), 32'h0);

      // 4: replace top of [11,22], then pop
      step(1, 1, 0, 8'h11, 0);
      step(1, 1, 0, 8'h22, 0);
      step(1, 1, 1, 8'h99, 0);
      chk_state("t4.repl", 8'h99, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1, 0, 1, 8'h00, 0);
      chk_state("t4.pop", 8'h11, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

      // 5: clock enable gating
      for (int k = 0; k < 3; k++) begin
         step(0, 1, 0, 8'h77, 0);
         chk("t5.hold.count", 32'(o_count), 32'd1);
         chk("t5.hold.top",   32'(o_top),   32'h11);
      end
      step(0, 0, 1, 8'h00, 0);
      chk("t5.holdpop", 32'(o_count), 32'd1);
      step(1, 1, 0, 8'h77, 0);
      chk_state("t5.en", 8'h77, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1, 0, 0, 8'h00, 0);
      chk("t5.once", 32'(o_count), 32'd2);

      // 6: async reset between edges, with overflow set
      step(1, 1, 0, 8'h01, 0);
      step(1, 1, 0, 8'h02, 0);
      step(1, 1, 0, 8'h03, 0);
      chk_state("t6.pre", 8'h02, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      i_push = 1'b1; i_push_data = 8'hEE;
      #2 rst = 1'b1;
      #1;
      chk_state("t6.rst", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      i_push = 1'b0;
      @(negedge mclk); rst = 1'b0;
      step(1, 1, 0, 8'hC3, 0);
      chk_state("t6.post", 8'hC3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
